// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clock_pkg
//  Purpose  : Shared types and constants for the clock edit controller:
//             edit-state encoding, display field indices and small helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package clock_pkg;

  // Edit state; the numeric value is exported directly as the mode code
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_H = 2'd1,
    ST_SET_M = 2'd2,
    ST_SET_S = 2'd3
  } edit_state_e;

  // Bit positions of each field inside the {hour, min, sec} masks
  localparam int HOUR = 2;
  localparam int MIN  = 1;
  localparam int SEC  = 0;

  // One-hot mask of the field being edited in a given state (zero in RUN)
  function automatic logic [2:0] field_mask(input edit_state_e s);
    logic [2:0] m;
    m = 3'b000;
    case (s)
      ST_SET_H: m[HOUR] = 1'b1;
      ST_SET_M: m[MIN]  = 1'b1;
      ST_SET_S: m[SEC]  = 1'b1;
      default:  m       = 3'b000;
    endcase
    return m;
  endfunction

  // Mode-button successor: RUN -> SET_H -> SET_M -> SET_S -> RUN
  function automatic edit_state_e next_state(input edit_state_e s);
    edit_state_e n;
    case (s)
      ST_RUN:   n = ST_SET_H;
      ST_SET_H: n = ST_SET_M;
      ST_SET_M: n = ST_SET_S;
      default:  n = ST_RUN;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/flicker_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : flicker_tick_gen
//  Purpose  : Prescaler counting 0..TICK_DIV-1; every wrap toggles the
//             flicker phase and flags a phase tick. A synchronous clear
//             restarts the period with the phase at 0 (field visible).
//  Revision : 1.0 - initial release
// ============================================================================
module flicker_tick_gen #(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic phase,
  output logic tick
);

  localparam int              c_cw   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(TICK_DIV - 1);

  logic [c_cw-1:0] r_cnt;
  logic            r_phase;

  // A tick is only reported when the wrap actually happens (not overridden by clr)
  assign tick  = (r_cnt == c_last) && !clr;
  assign phase = r_phase;

  // Prescaler and phase toggle, with clear taking priority over the wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (clr) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == c_last) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + c_cw'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/flicker_edit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : flicker_edit_ctrl
//  Purpose  : Two-button time-set controller. Mode presses walk through
//             RUN/SET_H/SET_M/SET_S, increment presses strobe the selected
//             counter, the selected field flickers, and an idle timeout
//             returns to RUN.
//  Revision : 1.0 - initial release
// ============================================================================
module flicker_edit_ctrl
  import clock_pkg::*;
#(
  parameter int TICK_DIV       = 10_000_000,
  parameter int TIMEOUT_PHASES = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [1:0] mode,
  output logic       run,
  output logic [2:0] blank,
  output logic       inc_h,
  output logic       inc_m,
  output logic       inc_s
);

  localparam int             c_iw          = (TIMEOUT_PHASES > 0) ? $clog2(TIMEOUT_PHASES + 1) : 1;
  localparam logic [c_iw-1:0] c_timeout_val = c_iw'(TIMEOUT_PHASES);

  logic            r_btn_mode_q;
  logic            r_btn_inc_q;
  logic            r_armed;
  edit_state_e     r_state;
  logic            r_run;
  logic [2:0]      r_blank;
  logic [2:0]      r_inc;
  logic [c_iw-1:0] r_idle;

  logic            w_mode_ev;
  logic            w_inc_ev;
  edit_state_e     w_state_nx;
  logic [2:0]      w_inc_nx;
  logic            w_clr;
  logic            w_phase;
  logic            w_tick;
  logic            w_phase_nx;
  logic [2:0]      w_blank_nx;
  logic [c_iw-1:0] w_idle_nx;

  // Events are gated until one cycle after reset so a button already held
  // at release first has to be seen low before it can count again
  assign w_mode_ev = r_armed & btn_mode & ~r_btn_mode_q;
  assign w_inc_ev  = r_armed & btn_inc  & ~r_btn_inc_q;

  flicker_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .phase (w_phase),
    .tick  (w_tick)
  );

  // Next-state decode: mode press beats inc press, any press beats timeout
  always_comb begin
    w_state_nx = r_state;
    w_inc_nx   = 3'b000;
    if (w_mode_ev) begin
      w_state_nx = next_state(r_state);
    end else if (w_inc_ev) begin
      w_inc_nx   = field_mask(r_state);
    end else if (r_state != ST_RUN && r_idle == c_timeout_val) begin
      w_state_nx = ST_RUN;
    end

    w_clr      = (w_state_nx != r_state) || (w_inc_nx != 3'b000);
    w_phase_nx = w_clr ? 1'b0 : (w_phase ^ w_tick);
    w_blank_nx = field_mask(w_state_nx) & {3{w_phase_nx}};

    w_idle_nx = r_idle;
    if (w_mode_ev || w_inc_ev || (w_state_nx != r_state)) begin
      w_idle_nx = '0;
    end else if (r_state != ST_RUN && w_tick && r_idle != c_timeout_val) begin
      w_idle_nx = r_idle + c_iw'(1);
    end
  end

  // Button history and post-reset arming
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_btn_mode_q <= 1'b0;
      r_btn_inc_q  <= 1'b0;
      r_armed      <= 1'b0;
    end else begin
      r_btn_mode_q <= btn_mode;
      r_btn_inc_q  <= btn_inc;
      r_armed      <= 1'b1;
    end
  end

  // Edit FSM with registered mode/run/blank/strobe outputs and idle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_run   <= 1'b1;
      r_blank <= 3'b000;
      r_inc   <= 3'b000;
      r_idle  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_run   <= (w_state_nx == ST_RUN);
      r_blank <= w_blank_nx;
      r_inc   <= w_inc_nx;
      r_idle  <= w_idle_nx;
    end
  end

  assign mode  = r_state;
  assign run   = r_run;
  assign blank = r_blank;
  assign inc_h = r_inc[HOUR];
  assign inc_m = r_inc[MIN];
  assign inc_s = r_inc[SEC];

endmodule
`default_nettype wire

// File: tb/tb_flicker_edit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flicker_edit_ctrl
//  Purpose  : Directed self-checking bench for flicker_edit_ctrl with
//             TICK_DIV=4 and TIMEOUT_PHASES=3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_flicker_edit_ctrl;

  logic       clk;
  logic       reset;
  logic       btn_mode;
  logic       btn_inc;
  logic [1:0] mode;
  logic       run;
  logic [2:0] blank;
  logic       inc_h;
  logic       inc_m;
  logic       inc_s;

  int n_vec;
  int n_err;
  int cnt_a;
  int cnt_b;

  flicker_edit_ctrl #(
    .TICK_DIV       (4),
    .TIMEOUT_PHASES (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .mode     (mode),
    .run      (run),
    .blank    (blank),
    .inc_h    (inc_h),
    .inc_m    (inc_m),
    .inc_s    (inc_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Press-and-release of the mode button: two cycles
  task automatic press_mode();
    btn_mode = 1'b1;
    tick();
    btn_mode = 1'b0;
    tick();
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    reset    = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_mode",  {30'd0, mode}, 32'd0);
    chk("rst_run",   {31'd0, run}, 32'd1);
    chk("rst_blank", {29'd0, blank}, 32'd0);
    chk("rst_inc",   {29'd0, inc_h, inc_m, inc_s}, 32'd0);
    reset = 1'b1;
    repeat (2) tick();

    // Mode walk 1,2,3,0
    btn_mode = 1'b1; tick();
    chk("walk_m1", {30'd0, mode}, 32'd1);
    chk("walk_r1", {31'd0, run}, 32'd0);
    chk("walk_b1", {29'd0, blank}, 32'd0);
    btn_mode = 1'b0; tick();
    btn_mode = 1'b1; tick();
    chk("walk_m2", {30'd0, mode}, 32'd2);
    chk("walk_r2", {31'd0, run}, 32'd0);
    btn_mode = 1'b0; tick();
    btn_mode = 1'b1; tick();
    chk("walk_m3", {30'd0, mode}, 32'd3);
    chk("walk_r3", {31'd0, run}, 32'd0);
    btn_mode = 1'b0; tick();
    btn_mode = 1'b1; tick();
    chk("walk_m0", {30'd0, mode}, 32'd0);
    chk("walk_r0", {31'd0, run}, 32'd1);
    btn_mode = 1'b0; tick();

    // SET_M flicker: 000 for 4 cycles, 010 for 4, then timeout back to RUN
    press_mode();
    btn_mode = 1'b1; tick();
    chk("flk_entry_mode", {30'd0, mode}, 32'd2);
    chk("flk_b0", {29'd0, blank}, 32'd0);
    btn_mode = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k <= 11) chk($sformatf("flk_b%0d", k), {29'd0, blank}, ((k / 4) % 2 == 1) ? 32'd2 : 32'd0);
      if (k == 12) begin
        chk("flk_to_hold", {30'd0, mode}, 32'd2);
        chk("flk_b12", {29'd0, blank}, 32'd2);
      end
      if (k == 13) begin
        chk("flk_to_mode", {30'd0, mode}, 32'd0);
        chk("flk_to_run", {31'd0, run}, 32'd1);
        chk("flk_to_blank", {29'd0, blank}, 32'd0);
      end
    end

    // SET_H timeout restarted by an increment press at cycle 10
    btn_mode = 1'b1; tick();
    btn_mode = 1'b0;
    chk("rst_to_entry", {30'd0, mode}, 32'd1);
    for (int k = 1; k <= 23; k++) begin
      tick();
      if (k == 9) btn_inc = 1'b1;
      if (k == 10) begin
        chk("rst_to_inc_on", {29'd0, inc_h, inc_m, inc_s}, 32'd4);
        btn_inc = 1'b0;
      end
      if (k == 11) chk("rst_to_inc_off", {29'd0, inc_h, inc_m, inc_s}, 32'd0);
      if (k == 13) chk("rst_to_m13", {30'd0, mode}, 32'd1);
      if (k == 22) chk("rst_to_m22", {30'd0, mode}, 32'd1);
      if (k == 23) chk("rst_to_m23", {30'd0, mode}, 32'd0);
    end

    // Held increment in SET_H: exactly one single-cycle inc_h
    press_mode();
    chk("hold_entry", {30'd0, mode}, 32'd1);
    btn_inc = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (inc_h) cnt_a++;
      if (inc_m || inc_s) cnt_b++;
    end
    chk("hold_inc_h_cycles", cnt_a, 32'd1);
    chk("hold_inc_ms", cnt_b, 32'd0);
    btn_inc = 1'b0; tick();
    chk("hold_timeout_mode", {30'd0, mode}, 32'd0);

    // Increment in RUN is ignored
    btn_inc = 1'b1;
    cnt_a = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (inc_h || inc_m || inc_s) cnt_a++;
    end
    chk("run_inc_ignored", cnt_a, 32'd0);
    btn_inc = 1'b0; tick();

    // Simultaneous mode+inc in SET_S: advance to RUN, no inc_s
    press_mode();
    press_mode();
    press_mode();
    chk("sim_entry", {30'd0, mode}, 32'd3);
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    tick();
    chk("sim_mode", {30'd0, mode}, 32'd0);
    chk("sim_run", {31'd0, run}, 32'd1);
    cnt_a = inc_s ? 1 : 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (inc_s) cnt_a++;
    end
    chk("sim_no_inc_s", cnt_a, 32'd0);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    tick();

    // Reset during SET_M with btn_mode held across release
    press_mode();
    press_mode();
    chk("mrst_entry", {30'd0, mode}, 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("mrst_mode", {30'd0, mode}, 32'd0);
    chk("mrst_run", {31'd0, run}, 32'd1);
    chk("mrst_blank", {29'd0, blank}, 32'd0);
    chk("mrst_inc", {29'd0, inc_h, inc_m, inc_s}, 32'd0);
    btn_mode = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("mrst_held_%0d", k), {30'd0, mode}, 32'd0);
    end
    btn_mode = 1'b0; tick();
    chk("mrst_released", {30'd0, mode}, 32'd0);
    btn_mode = 1'b1; tick();
    chk("mrst_repress", {30'd0, mode}, 32'd1);
    btn_mode = 1'b0; tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flicker_edit_ctrl.md
FLICKER_EDIT_CTRL -- requirements
Module: flicker_edit_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 10_000_000, clk cycles per flicker phase (0.1 s at 100 MHz).
REQ-002 Parameter TIMEOUT_PHASES, default 100, idle flicker phases before auto-exit from edit (10 s).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 btn_mode  input  1  debounced, clk-synchronous level of the mode button; 1 = pressed.
REQ-006 btn_inc  input  1  debounced, clk-synchronous level of the increment button; 1 = pressed.
REQ-007 mode  output  2  current state code: 0 RUN, 1 SET_H, 2 SET_M, 3 SET_S.
REQ-008 run  output  1  timekeeping enable; 1 only in RUN.
REQ-009 blank  output  3  per-field blank mask {hour, min, sec}; 1 = field dark.
REQ-010 inc_h, inc_m, inc_s  output  1 each  single-cycle increment strobes to the hour/min/sec counters.

Function
REQ-011 Button press events shall be rising edges detected against a one-cycle registered copy of each button.
REQ-012 The FSM shall cycle RUN -> SET_H -> SET_M -> SET_S -> RUN, advancing one state per btn_mode press event; there are no other transitions except timeout and reset.
REQ-013 A btn_inc press event in SET_H/SET_M/SET_S shall assert inc_h/inc_m/inc_s respectively for exactly one cycle, the cycle after the event is detected; in RUN it is ignored.
REQ-014 Simultaneous btn_mode and btn_inc press events: the mode advance shall occur and no inc strobe shall be issued.
REQ-015 A held button shall produce one event only; no auto-repeat.
REQ-016 The prescaler shall count 0..TICK_DIV-1 and wrap; each wrap shall toggle the flicker phase bit and produce one phase tick.
REQ-017 On every state change and on every inc strobe, the prescaler and phase bit shall clear to 0 (field visible) in the same cycle.
REQ-018 In a SET state, the blank bit of the selected field shall equal the phase bit; all other blank bits shall be 0; in RUN blank shall be 000.
REQ-019 The idle counter shall count phase ticks in SET states, clear on any press event or state change, and on reaching TIMEOUT_PHASES shall force RUN on the next cycle.
REQ-020 Timeout and a press event in the same cycle: the press event shall be handled and the timeout discarded.
REQ-021 run, mode and blank shall be registered outputs; mode/run shall update one cycle after the press event.
REQ-022 Prescaler width shall be $clog2(TICK_DIV); idle counter width $clog2(TIMEOUT_PHASES+1); no counter shall overflow.

Reset
REQ-023 While reset is 0: state RUN, mode 0, run 1, blank 000, all inc strobes 0, prescaler/phase/idle counters 0, button history registers 0.
REQ-024 Reset asserted mid-edit shall abandon the edit immediately with no inc strobe issued.
REQ-025 A button held during reset release shall not produce a press event until released and pressed again.

Structure
REQ-026 The state encoding enum and the field-index constants (HOUR=2, MIN=1, SEC=0) shall reside in the shared package clock_pkg.
REQ-027 The prescaler/phase generator shall be one sub-module, flicker_tick_gen, with a synchronous clear input, a phase output and a tick output.

Verification
REQ-028 Reset, then 4 btn_mode presses -> mode 1,2,3,0 in turn; run 0 in modes 1-3 and 1 after returning to mode 0.
REQ-029 TICK_DIV=4, SET_M -> blank toggles 000/010 every 4 cycles, starting at 000 on entry.
REQ-030 SET_H, btn_inc held 20 cycles -> exactly one inc_h pulse, 1 cycle wide; inc_m/inc_s stay 0.
REQ-031 btn_mode and btn_inc rise in the same cycle in SET_S -> mode 0, run 1, no inc_s pulse.
REQ-032 TICK_DIV=4, TIMEOUT_PHASES=3, SET_H with no presses -> mode 0 after 12 cycles of idle plus 1; one press at cycle 10 restarts the count.
REQ-033 Reset asserted during SET_M with btn_mode held across release -> mode 0, blank 000, no mode advance until btn_mode falls and rises again.
